wordbank4_demux: RTL and testbench

//  Write-side counterpart of the 4:1 word read mux. Buffers incoming (sel, word) writes
//  in a small in-order FIFO and drains them one per cycle into one of four word registers.
//  The four registered outputs feed the 4:1 read-mux path directly.

---
 rtl/wordbank4_demux_if.sv | 31 +++
 rtl/wordbank4_demux.sv | 86 ++++++++
 tb/tb_wordbank4_demux.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wordbank4_demux_if.sv
// Write-side bus of the 4-entry register bank: buffered (sel, word) writes in,
// the four register values, update strobes and buffer occupancy out.
interface wordbank4_demux_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [1:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             hold;
  logic             clear;
  logic [WIDTH-1:0] val0;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] val3;
  logic [3:0]       upd;
  logic [CW-1:0]    count;

  modport master (
    output wr_valid, wr_sel, wr_data, hold, clear,
    input  wr_ready, val0, val1, val2, val3, upd, count
  );

  modport slave (
    input  wr_valid, wr_sel, wr_data, hold, clear,
    output wr_ready, val0, val1, val2, val3, upd, count
  );
endinterface

// File: rtl/wordbank4_demux.sv
// Write-back stage of the 4-entry register bank: in-order write buffer draining one
// entry per cycle into four word registers that feed the 4:1 read mux.
module wordbank4_demux #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  wordbank4_demux_if.slave wb
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [1:0]       mem_sel_q  [DEPTH];
  logic [WIDTH-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] val_q [4];
  logic [3:0]       upd_q;

  logic push;
  logic pop;
  logic ready;

  // Ready ignores any drain in the same cycle, so a full buffer never passes through.
  assign ready = !i_rst && !wb.clear && (count_q < DepthC);

  always_comb begin
    push = wb.wr_valid && ready;
    pop  = (count_q != '0) && !wb.hold && !wb.clear;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_sel_q[k]  <= '0;
        mem_data_q[k] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        val_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      upd_q    <= '0;
    end else if (wb.clear) begin
      for (int k = 0; k < 4; k++) begin
        val_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      upd_q    <= '0;
    end else begin
      if (push) begin
        mem_sel_q[wr_ptr_q]  <= wb.wr_sel;
        mem_data_q[wr_ptr_q] <= wb.wr_data;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        val_q[mem_sel_q[rd_ptr_q]] <= mem_data_q[rd_ptr_q];
        upd_q                      <= 4'b0001 << mem_sel_q[rd_ptr_q];
        rd_ptr_q                   <= rd_ptr_q + PW'(1);
      end else begin
        upd_q <= '0;
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign wb.wr_ready = ready;
  assign wb.val0     = val_q[0];
  assign wb.val1     = val_q[1];
  assign wb.val2     = val_q[2];
  assign wb.val3     = val_q[3];
  assign wb.upd      = upd_q;
  assign wb.count    = count_q;

endmodule

// File: tb/tb_wordbank4_demux.sv
// Directed table plus hand sequences and a random run against a queue model
// for the buffered 4-register write-back stage.
module tb_wordbank4_demux;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  wordbank4_demux_if #(.WIDTH(16), .DEPTH(2)) wb ();

  wordbank4_demux #(.WIDTH(16), .DEPTH(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  sel;
    logic [15:0] data;
    logic        hold;
    logic        clr;
    logic        ready;  // expected before the edge
    logic [3:0]  upd;    // expected after the edge
    logic [1:0]  count;
    logic [15:0] v0;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] v3;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
  } ent_t;

  vec_t tbl [20];
  ent_t q [$];
  logic [15:0] m_val [4];
  logic [3:0]  m_upd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d,
                       input logic h, input logic c);
    wb.wr_valid = v;
    wb.wr_sel   = s;
    wb.wr_data  = d;
    wb.hold     = h;
    wb.clear    = c;
  endtask

  task automatic chk_vals(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    chk({tag, " val0"}, 32'(wb.val0), 32'(e0));
    chk({tag, " val1"}, 32'(wb.val1), 32'(e1));
    chk({tag, " val2"}, 32'(wb.val2), 32'(e2));
    chk({tag, " val3"}, 32'(wb.val3), 32'(e3));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);

    //           vld  sel   data      hold  clr   rdy   upd      cnt   v0       v1       v2       v3
    tbl[0]  = '{1'b1, 2'd2, 16'hBEEF, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1, 16'h0,    16'h0,    16'h0,    16'h0};
    tbl[1]  = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b0, 1'b1, 4'b0100, 2'd0, 16'h0,    16'h0,    16'hBEEF, 16'h0};
    tbl[2]  = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 16'h0,    16'h0,    16'hBEEF, 16'h0};
    tbl[3]  = '{1'b1, 2'd0, 16'h1111, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd1, 16'h0,    16'h0,    16'hBEEF, 16'h0};
    tbl[4]  = '{1'b1, 2'd1, 16'h2222, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd2, 16'h0,    16'h0,    16'hBEEF, 16'h0};
    tbl[5]  = '{1'b1, 2'd3, 16'h3333, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 16'h0,    16'h0,    16'hBEEF, 16'h0};
    tbl[6]  = '{1'b1, 2'd3, 16'h3333, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd1, 16'h1111, 16'h0,    16'hBEEF, 16'h0};
    tbl[7]  = '{1'b1, 2'd3, 16'h3333, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 16'h1111, 16'h2222, 16'hBEEF, 16'h0};
    tbl[8]  = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b0, 1'b1, 4'b1000, 2'd0, 16'h1111, 16'h2222, 16'hBEEF, 16'h3333};
    tbl[9]  = '{1'b1, 2'd1, 16'h000A, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1, 16'h1111, 16'h2222, 16'hBEEF, 16'h3333};
    tbl[10] = '{1'b1, 2'd1, 16'h000B, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 16'h1111, 16'h000A, 16'hBEEF, 16'h3333};
    tbl[11] = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b0, 1'b1, 4'b0010, 2'd0, 16'h1111, 16'h000B, 16'hBEEF, 16'h3333};
    tbl[12] = '{1'b1, 2'd0, 16'h0AAA, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd1, 16'h1111, 16'h000B, 16'hBEEF, 16'h3333};
    tbl[13] = '{1'b1, 2'd2, 16'h0BBB, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd2, 16'h1111, 16'h000B, 16'hBEEF, 16'h3333};
    tbl[14] = '{1'b1, 2'd3, 16'h0CCC, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0};
    tbl[15] = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0};
    tbl[16] = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0};
    tbl[17] = '{1'b1, 2'd3, 16'h1234, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1, 16'h0,    16'h0,    16'h0,    16'h0};
    tbl[18] = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0};
    tbl[19] = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0};

    // Power-on reset held across edges.
    step();
    step();
    chk("por ready", 32'(wb.wr_ready), 32'd0);
    chk("por count", 32'(wb.count), 32'd0);
    chk("por upd", 32'(wb.upd), 32'd0);
    chk_vals("por", 16'h0, 16'h0, 16'h0, 16'h0);
    rst = 1'b0;
    #1;
    chk("por release ready", 32'(wb.wr_ready), 32'd1);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].valid, tbl[i].sel, tbl[i].data, tbl[i].hold, tbl[i].clr);
      #1;
      chk($sformatf("v%0d ready", i), 32'(wb.wr_ready), 32'(tbl[i].ready));
      step();
      chk($sformatf("v%0d upd", i), 32'(wb.upd), 32'(tbl[i].upd));
      chk($sformatf("v%0d count", i), 32'(wb.count), 32'(tbl[i].count));
      chk_vals($sformatf("v%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].v2, tbl[i].v3);
    end

    // Asynchronous reset between edges with two writes buffered.
    drive(1'b1, 2'd0, 16'h5555, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'd1, 16'h6666, 1'b0, 1'b0);
    step();
    chk("pre-rst val0", 32'(wb.val0), 32'h5555);
    drive(1'b1, 2'd2, 16'h7777, 1'b1, 1'b0);
    step();
    chk("pre-rst count", 32'(wb.count), 32'd2);
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst count", 32'(wb.count), 32'd0);
    chk("async rst ready", 32'(wb.wr_ready), 32'd0);
    chk("async rst upd", 32'(wb.upd), 32'd0);
    chk_vals("async rst", 16'h0, 16'h0, 16'h0, 16'h0);
    rst = 1'b0;
    #1;
    chk("rst release ready", 32'(wb.wr_ready), 32'd1);
    step();
    step();
    chk("post-rst upd", 32'(wb.upd), 32'd0);
    chk("post-rst count", 32'(wb.count), 32'd0);
    chk_vals("post-rst", 16'h0, 16'h0, 16'h0, 16'h0);

    // Random traffic against a queue model; registers start from zero.
    for (int k = 0; k < 4; k++) m_val[k] = 16'h0;
    m_upd = 4'b0;
    q.delete();
    for (int c = 0; c < 1000; c++) begin
      logic v, h, cl, exp_rdy;
      logic [1:0] s;
      logic [15:0] d;
      ent_t e;
      v  = ($urandom_range(0, 9) < 7);
      h  = ($urandom_range(0, 9) < 3);
      cl = ($urandom_range(0, 99) < 3);
      s  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      drive(v, s, d, h, cl);
      #1;
      exp_rdy = !cl && (q.size() < 2);
      chk($sformatf("rnd%0d ready", c), 32'(wb.wr_ready), 32'(exp_rdy));
      if (cl) begin
        q.delete();
        for (int k = 0; k < 4; k++) m_val[k] = 16'h0;
        m_upd = 4'b0;
      end else begin
        if (q.size() > 0 && !h) begin
          e = q.pop_front();
          m_val[e.sel] = e.data;
          m_upd = 4'b0001 << e.sel;
        end else begin
          m_upd = 4'b0;
        end
        if (v && exp_rdy) begin
          e.sel  = s;
          e.data = d;
          q.push_back(e);
        end
      end
      step();
      chk($sformatf("rnd%0d upd", c), 32'(wb.upd), 32'(m_upd));
      chk($sformatf("rnd%0d count", c), 32'(wb.count), 32'(q.size()));
    end
    chk_vals("rnd final", m_val[0], m_val[1], m_val[2], m_val[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
